// File: rtl/sm4_axis128_to_axis8.sv
// sm4_axis128_to_axis8: serialises 128-bit SM4 result blocks onto an 8-bit AXI-Stream master
module sm4_axis128_to_axis8 #(
   parameter int TUSER_W   = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [127:0]       s_axis_tdata,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   input  logic               s_axis_tlast,
   input  logic [3:0]         s_axis_tcnt,
   input  logic [TUSER_W-1:0] s_axis_tuser,
   output logic [7:0]         m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tlast,
   output logic [TUSER_W-1:0] m_axis_tuser
);
   localparam logic [0:0] IDLE = 1'b0, SEND = 1'b1;
   logic [0:0]   state;
   logic [127:0] data_q;
   logic [3:0]   len, idx, k;
   logic         last_q, hs, done, acc;
   assign m_axis_tvalid = state == SEND;
   assign hs            = m_axis_tvalid && m_axis_tready;
   assign done          = hs && idx == len;
   assign s_axis_tready = state == IDLE || done;
   assign acc           = s_axis_tvalid && s_axis_tready;
   assign k             = MSB_FIRST ? ~idx : idx;
   assign m_axis_tdata  = data_q[{k, 3'b000} +: 8];
   assign m_axis_tlast  = m_axis_tvalid && last_q && idx == len;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state        <= IDLE;
         data_q       <= '0;
         len          <= '0;
         idx          <= '0;
         last_q       <= 1'b0;
         m_axis_tuser <= '0;
      end else if (acc) begin
         state        <= SEND;
         data_q       <= s_axis_tdata;
         len          <= s_axis_tcnt;
         idx          <= '0;
         last_q       <= s_axis_tlast;
         m_axis_tuser <= s_axis_tuser;
      end else if (done) begin
         state <= IDLE;
         idx   <= '0;
      end else if (hs)
         idx <= idx + 4'd1;
endmodule

// File: tb/tb_sm4_axis128_to_axis8.sv
// tb_sm4_axis128_to_axis8: checks MSB-first and LSB-first instances against a byte-queue reference model
module tb_sm4_axis128_to_axis8;
   typedef struct {
      logic [127:0] data;
      logic [3:0]   cnt;
      logic         last;
      logic [7:0]   user;
   } blk_t;
   typedef struct {
      blk_t       b;
      logic [7:0] msb_first, msb_final, lsb_first, lsb_final;
   } vec_t;
   typedef struct {
      logic [7:0] d;
      logic       l;
      logic [7:0] u;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0;
   logic s_tready_a, s_tready_b, a_tvalid, b_tvalid, a_tlast, b_tlast;
   logic [7:0] a_tdata, b_tdata, a_tuser, b_tuser;
   blk_t cur = '{128'h0, 4'h0, 1'b0, 8'h0};

   always #5 clk = ~clk;

   sm4_axis128_to_axis8 #(.TUSER_W(8), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .s_axis_tdata(cur.data), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready_a), .s_axis_tlast(cur.last), .s_axis_tcnt(cur.cnt),
      .s_axis_tuser(cur.user), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser));
   sm4_axis128_to_axis8 #(.TUSER_W(8), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .s_axis_tdata(cur.data), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready_b), .s_axis_tlast(cur.last), .s_axis_tcnt(cur.cnt),
      .s_axis_tuser(cur.user), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser));

   int ncmp = 0, nerr = 0;
   exp_t expa[$], expb[$];
   blk_t srcq[$];
   bit acc, stall_prev;
   logic [16:0] prev_out;
   int nbytes, nvalid, nsr, cyc, firstv, lastv;
   logic [7:0] fin_a, fin_b;
   logic fin_last;

   task automatic chk(string name, logic [127:0] act, logic [127:0] req);
      ncmp++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference serialisation: byte b of a block is a plain shift of the 128-bit word.
   function automatic void push_exp(blk_t b);
      for (int i = 0; i <= int'(b.cnt); i++) begin
         expa.push_back('{8'(b.data >> (8 * (15 - i))), b.last && i == int'(b.cnt), b.user});
         expb.push_back('{8'(b.data >> (8 * i)), b.last && i == int'(b.cnt), b.user});
      end
   endfunction

   task automatic cycle();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (a_tvalid) begin
         nvalid++;
         if (firstv < 0) firstv = cyc;
         lastv = cyc;
         if (s_tready_a) nsr++;
      end
      if (stall_prev) chk("stall_hold", {a_tvalid, a_tdata, a_tlast, a_tuser}, {1'b1, prev_out});
      if (a_tvalid && m_tready) begin
         chk("byte_avail_a", expa.size() != 0, 1);
         if (expa.size() != 0) begin
            e = expa.pop_front();
            chk("byte_a", {a_tdata, a_tlast, a_tuser}, {e.d, e.l, e.u});
         end
         fin_a = a_tdata;
         fin_last = a_tlast;
         nbytes++;
      end
      if (b_tvalid && m_tready) begin
         chk("byte_avail_b", expb.size() != 0, 1);
         if (expb.size() != 0) begin
            e = expb.pop_front();
            chk("byte_b", {b_tdata, b_tlast, b_tuser}, {e.d, e.l, e.u});
         end
         fin_b = b_tdata;
      end
      acc = s_tvalid && s_tready_a && rst_n;
      if (acc) push_exp(cur);
      stall_prev = a_tvalid && !m_tready && rst_n;
      prev_out = {a_tdata, a_tlast, a_tuser};
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      nbytes = 0; nvalid = 0; nsr = 0; firstv = -1; lastv = -1;
   endtask

   task automatic run(int rp, int vp, int maxc);
      for (int c = 0; c < maxc; c++) begin
         if (!s_tvalid && srcq.size() != 0 && $urandom_range(99) < vp) begin
            cur = srcq.pop_front();
            s_tvalid = 1'b1;
         end
         m_tready = $urandom_range(99) < rp;
         cycle();
         if (acc) s_tvalid = 1'b0;
         if (srcq.size() == 0 && !s_tvalid && expa.size() == 0 && expb.size() == 0 && !a_tvalid) return;
      end
      chk("run_drained", srcq.size() + expa.size() + expb.size() + int'(s_tvalid) + int'(a_tvalid), 0);
   endtask

   vec_t vt[4];
   blk_t bk;

   initial begin
      vt[0] = '{'{128'h0123456789abcdeffedcba9876543210, 4'd15, 1'b1, 8'h09}, 8'h01, 8'h10, 8'h10, 8'h01};
      vt[1] = '{'{128'hA1A2A3A4A5 << 88, 4'd4, 1'b1, 8'h77}, 8'hA1, 8'hA5, 8'h00, 8'h00};
      vt[2] = '{'{128'h00112233445566778899aabbccddeeff, 4'd0, 1'b0, 8'h5A}, 8'h00, 8'h00, 8'hff, 8'hff};
      vt[3] = '{'{128'h00112233445566778899aabbccddeeff, 4'd7, 1'b1, 8'h3C}, 8'h00, 8'h77, 8'hff, 8'h88};
      #12;
      chk("reset_out", {s_tready_a, a_tvalid, a_tdata, a_tlast, a_tuser, b_tvalid, b_tdata},
          {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00});
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      // Directed blocks: latency, order, final byte and tlast for both byte orders.
      foreach (vt[i]) begin
         clear_stats();
         cur = vt[i].b; s_tvalid = 1'b1; m_tready = 1'b1;
         cycle();
         chk("accept", acc, 1);
         s_tvalid = 1'b0;
         chk("first_byte", {a_tvalid, a_tdata, b_tdata, a_tuser}, {1'b1, vt[i].msb_first, vt[i].lsb_first, vt[i].b.user});
         for (int c = 0; c < 20 && a_tvalid; c++) cycle();
         chk("nbytes", nbytes, int'(vt[i].b.cnt) + 1);
         chk("final_byte", {fin_a, fin_b, fin_last}, {vt[i].msb_final, vt[i].lsb_final, vt[i].b.last});
         chk("idle_after", {a_tvalid, s_tready_a}, 2'b01);
      end
      // Back-to-back blocks must stream 32 bytes with no bubble.
      clear_stats();
      srcq.push_back('{128'h0123456789abcdeffedcba9876543210, 4'd15, 1'b0, 8'h11});
      srcq.push_back('{128'hffeeddccbbaa99887766554433221100, 4'd15, 1'b1, 8'h22});
      run(100, 100, 100);
      chk("b2b_valid_cycles", nvalid, 32);
      chk("b2b_no_gap", lastv - firstv + 1, 32);
      chk("b2b_sready_cycles", nsr, 2);
      // Random backpressure and source gaps over 4 packets of 3 blocks.
      for (int p = 0; p < 4; p++)
         for (int j = 0; j < 3; j++) begin
            bk.data = {$urandom, $urandom, $urandom, $urandom};
            bk.cnt = ($urandom_range(1) != 0) ? 4'd15 : 4'($urandom_range(15));
            bk.last = j == 2;
            bk.user = 8'($urandom);
            srcq.push_back(bk);
         end
      clear_stats();
      run(50, 70, 3000);
      chk("rand_nbytes_nonzero", nbytes >= 12, 1);
      // Reset mid-block on byte 7, then a fresh block must start at byte 0.
      clear_stats();
      cur = '{128'h0123456789abcdeffedcba9876543210, 4'd15, 1'b1, 8'h44};
      s_tvalid = 1'b1; m_tready = 1'b1;
      cycle();
      s_tvalid = 1'b0;
      for (int c = 0; c < 20 && nbytes < 7; c++) cycle();
      chk("pre_reset_byte7", {a_tvalid, a_tdata}, {1'b1, 8'hef});
      rst_n = 1'b0;
      #1;
      chk("reset_mid", {a_tvalid, a_tdata, a_tlast, a_tuser, b_tvalid, b_tdata, b_tuser},
          {1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00});
      expa.delete(); expb.delete(); stall_prev = 1'b0;
      cycle();
      rst_n = 1'b1;
      #1;
      chk("post_reset_sready", s_tready_a, 1);
      cur = '{128'hfedcba98765432100123456789abcdef, 4'd15, 1'b0, 8'h55};
      s_tvalid = 1'b1;
      cycle();
      s_tvalid = 1'b0;
      chk("post_reset_byte0", {a_tvalid, a_tdata, b_tdata, a_tuser}, {1'b1, 8'hfe, 8'hef, 8'h55});
      run(100, 100, 100);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/sm4_axis128_to_axis8.md
Name: sm4_axis128_to_axis8

Overview:
Output-side width converter for the SM4 byte-stream datapath. It accepts 128-bit SM4 result blocks with block-level valid/ready, packet-end and user tags, and serialises each block MSB byte first onto an 8-bit AXI-Stream master. It is the transmit-direction counterpart of the 8-to-128 input packer in front of the SM4 core, and it drives the 8-bit m_axis interface that downstream consumers and benches read.

Parameters:
TUSER_W, 8, width of the tuser sideband, carried unchanged per block.
MSB_FIRST, 1, 1: byte 0 on the wire = data[127:120]; 0: byte 0 = data[7:0].

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  128  SM4 result block
s_axis_tvalid  in  1  block valid
s_axis_tready  out  1  block accepted when tvalid&&tready at clk edge
s_axis_tlast  in  1  block is the last of its packet
s_axis_tcnt  in  4  valid bytes in block minus 1 (15 = full 16 bytes)
s_axis_tuser  in  TUSER_W  block user tag
m_axis_tdata  out  8  output byte
m_axis_tvalid  out  1  byte valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last byte of packet
m_axis_tuser  out  TUSER_W  tag of the block the byte belongs to

Behaviour:
- Reset (rst_n low, asynchronous): m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, byte index=0, state=IDLE. Any in-flight block is discarded and never resumed.
- After reset, s_axis_tready=1 (combinational from IDLE).
- States:
  - IDLE: no block held, m_axis_tvalid=0.
  - SEND: block held, m_axis_tvalid=1.
- s_axis_tready = (state==IDLE) || (m_axis_tvalid && m_axis_tready && idx==len). Purely combinational from state and m_axis_tready; it has no path from s_axis_tvalid.
- Block accept at edge N:
  - Latch data, tlast, tcnt into len, and tuser. Set idx=0 and state=SEND.
  - Byte 0 appears on m_axis registered at N+1. Latency is 1 cycle.
- Byte handshake (m_axis_tvalid && m_axis_tready):
  - If idx<len: idx increments and the next byte is presented on the next cycle.
  - If idx==len with no new block accepted in the same cycle: state goes to IDLE and m_axis_tvalid drops.
  - If idx==len and a new block is accepted in the same cycle: go straight to byte 0 of the new block. There is no bubble, so the sustained rate is 1 byte/cycle.
- Byte select: idx k selects data[127-8k -: 8] when MSB_FIRST=1, otherwise data[8k+7 -: 8]. idx is 4 bits and never wraps past len.
- m_axis_tlast=1 only while idx==len and the held block's tlast=1. It is 0 on all other bytes, including the final byte of a non-last block.
- m_axis_tuser is constant for all bytes of a block.
- Stall: while m_axis_tvalid && !m_axis_tready, m_axis_tdata, m_axis_tlast and m_axis_tuser hold stable and idx does not change (AXIS rule).
- Partial block (tcnt<15): exactly tcnt+1 bytes are emitted. Remaining block bytes are dropped.
- s_axis_tvalid while s_axis_tready=0: no effect. The upstream source must hold its data.
- Reset asserted mid-block: outputs clear immediately. After release, the first byte seen is byte 0 of a newly accepted block.

Test Plan:
- Full block data=128'h0123456789abcdeffedcba9876543210, tcnt=15, tlast=1, tuser=8'h09, m_tready=1 -> 16 consecutive bytes 01 23 45 67 89 ab cd ef fe dc ba 98 76 54 32 10. First byte one cycle after accept. tlast only on byte 10. tuser=09 on all bytes.
- Two back-to-back blocks, the first with tlast=0, m_tready held 1 -> 32 consecutive valid cycles with no gap. s_axis_tready high only in IDLE and on the 16th byte cycle. tlast only on byte 32.
- Partial block tcnt=4, tlast=1, data=128'hA1A2A3A4A5_0000... -> bytes A1 A2 A3 A4 A5 with tlast on A5, then tvalid=0.
- Random m_tready (~50%) over 4 packets of 3 blocks each -> captured byte stream equals the reference serialisation. Outputs are stable during every stall cycle. No byte is lost or duplicated.
- rst_n pulsed low on byte 7 of a block -> tvalid/tdata/tlast/tuser=0 within the same cycle. After release, s_axis_tready=1 and the next output is byte 0 of the next block.
- MSB_FIRST=0 instance with the scenario-1 block -> bytes 10 32 54 76 98 ba dc fe ef cd ab 89 67 45 23 01.
